// File: rtl/pipelined_approx_adder_if.sv
// Valid/ready stream bundle for pipelined_approx_adder.
// The master drives operands and out_ready; the slave (the adder) drives
// in_ready and the result.
interface pipelined_approx_adder_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             approx_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;

    modport master (
        output in_valid, a, b, approx_en, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, a, b, approx_en, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/pipelined_approx_adder.sv
// Pipelined unsigned adder split into STAGES carry segments with a register
// after each segment. The lower APPROX_BITS bits can be computed with a
// lower-part-OR approximation, selected per beat by approx_en.
// The whole pipe advances on a single enable: en = !out_valid || out_ready.
// Optional macro ADDER_ERR_STATS_EN adds a shadow exact sum per beat and
// error statistics (err_count, err_max, cleared by stats_clr).
module pipelined_approx_adder #(
    parameter int WIDTH       = 12,
    parameter int STAGES      = 3,
    parameter int APPROX_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    pipelined_approx_adder_if.slave    s
`ifdef ADDER_ERR_STATS_EN
    ,
    input  logic                       stats_clr,
    output logic [31:0]                err_count,
    output logic [WIDTH:0]             err_max
`endif
);
    // Bits handled per segment; the last non-empty segment takes the remainder.
    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    logic             en;

    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             mode_q  [STAGES];
    logic             mode_d  [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] psum_q  [STAGES];
    logic [WIDTH-1:0] psum_d  [STAGES];

    // Per-stage working values while walking the pipe.
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] p_i;
    logic             c_i;
    logic             m_i;
    logic             v_i;
    int               kp;

    // Next-state of every stage: pick up the previous stage (or the input
    // port for stage 0) and resolve this stage's slice of the carry chain.
    always_comb begin
        en = !valid_q[STAGES-1] || s.out_ready;
        a_i = '0;
        b_i = '0;
        p_i = '0;
        c_i = 1'b0;
        m_i = 1'b0;
        v_i = 1'b0;
        kp  = 0;
        for (int k = 0; k < STAGES; k++) begin
            kp = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                a_i = s.a;
                b_i = s.b;
                p_i = '0;
                c_i = 1'b0;
                m_i = s.approx_en;
                v_i = s.in_valid;
            end else begin
                a_i = a_q[kp];
                b_i = b_q[kp];
                p_i = psum_q[kp];
                c_i = carry_q[kp];
                m_i = mode_q[kp];
                v_i = valid_q[kp];
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= k * SEG && i < (k + 1) * SEG) begin
                    if (m_i && i < APPROX_BITS) begin
                        // LOA: OR the bits; only the top approximate bit
                        // generates a carry into the exact upper part.
                        p_i[i] = a_i[i] | b_i[i];
                        c_i    = (i == APPROX_BITS - 1) ? (a_i[i] & b_i[i]) : 1'b0;
                    end else begin
                        p_i[i] = a_i[i] ^ b_i[i] ^ c_i;
                        c_i    = (a_i[i] & b_i[i]) | (c_i & (a_i[i] ^ b_i[i]));
                    end
                end
            end
            a_d[k]     = a_i;
            b_d[k]     = b_i;
            psum_d[k]  = p_i;
            carry_d[k] = c_i;
            mode_d[k]  = m_i;
            valid_d[k] = v_i;
        end
    end

    // Stage registers: cleared by reset, frozen together while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                mode_q[k]  <= 1'b0;
                carry_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                psum_q[k]  <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                mode_q[k]  <= mode_d[k];
                carry_q[k] <= carry_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                psum_q[k]  <= psum_d[k];
            end
        end
    end

    assign s.in_ready  = en;
    assign s.out_valid = valid_q[STAGES-1];
    assign s.sum       = {carry_q[STAGES-1], psum_q[STAGES-1]};

`ifdef ADDER_ERR_STATS_EN
    logic [WIDTH:0] exact_q [STAGES];
    logic [WIDTH:0] exact_d [STAGES];
    logic [31:0]    err_count_q;
    logic [31:0]    err_count_d;
    logic [WIDTH:0] err_max_q;
    logic [WIDTH:0] err_max_d;
    logic [WIDTH:0] err_abs;
    logic           retire;

    // Shadow exact sum rides alongside each beat.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                exact_d[k] = {1'b0, s.a} + {1'b0, s.b};
            end else begin
                exact_d[k] = exact_q[(k == 0) ? 0 : k - 1];
            end
        end
    end

    // Error statistics, updated only when a result leaves the block.
    always_comb begin
        retire      = s.out_valid && s.out_ready;
        err_abs     = (s.sum >= exact_q[STAGES-1]) ? (s.sum - exact_q[STAGES-1])
                                                   : (exact_q[STAGES-1] - s.sum);
        err_count_d = err_count_q;
        err_max_d   = err_max_q;
        if (stats_clr) begin
            err_count_d = '0;
            err_max_d   = '0;
        end else if (retire) begin
            if (err_abs != '0 && err_count_q != 32'hFFFF_FFFF) begin
                err_count_d = err_count_q + 32'd1;
            end
            if (err_abs > err_max_q) begin
                err_max_d = err_abs;
            end
        end
    end

    // Shadow and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                exact_q[k] <= '0;
            end
            err_count_q <= '0;
            err_max_q   <= '0;
        end else begin
            if (en) begin
                for (int k = 0; k < STAGES; k++) begin
                    exact_q[k] <= exact_d[k];
                end
            end
            err_count_q <= err_count_d;
            err_max_q   <= err_max_d;
        end
    end

    assign err_count = err_count_q;
    assign err_max   = err_max_q;
`endif
endmodule
